multi_controller_poll: RTL and testbench

- Parametrised successor to the fixed two-pad serial controller interface.
- Polls NUM_CONTROLLERS NES-style shift-register pads in parallel on a shared latch and shift clock, with a programmable shift-clock rate and button count.
- Publishes all button states atomically, active-high, after each poll. Runs in the CPU clock domain.
- Typically kicked once per frame from the vblank pulse; results are read by the CPU through the memory-mapped controller registers.

---
 rtl/multi_controller_poll.sv | 127 ++++++++++++
 tb/tb_multi_controller_poll.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_controller_poll.sv
// rtl/multi_controller_poll.sv - parallel NES-style pad poller with shared latch/clock
// Optional macro CONTROLLER_PRESSED_EDGE_EN adds pressed_out (newly pressed buttons per poll).
module multi_controller_poll #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int BUTTONS         = 8,
  parameter int CLK_DIV         = 4
) (
  input  logic                                 clk_1,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 controller_latch,
  output logic                                 controller_clk,
  input  logic [NUM_CONTROLLERS-1:0]           controller_data_in_B,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0]   buttons_out
`ifdef CONTROLLER_PRESSED_EDGE_EN
  ,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0]   pressed_out
`endif
);

  localparam int CW = $clog2(2*CLK_DIV) + 1;
  localparam int IW = $clog2(BUTTONS) + 1;
  localparam logic [CW-1:0] LATCH_LAST = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BUTTONS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_READ, S_CLK_HIGH, S_CLK_LOW, S_DONE
  } state_t;

  state_t                               state;
  logic [CW-1:0]                        cnt;
  logic [IW-1:0]                        idx;
  logic [NUM_CONTROLLERS*BUTTONS-1:0]   shreg;
  logic [NUM_CONTROLLERS*BUTTONS-1:0]   sampled;

  // Shift registers with the bit being read this cycle merged in, so the final
  // READ can publish a complete poll on the same edge it samples the last bit.
  always_comb begin
    sampled = shreg;
    for (int c = 0; c < NUM_CONTROLLERS; c++) begin
      for (int k = 0; k < BUTTONS; k++) begin
        if (idx == IW'(k)) sampled[c*BUTTONS + k] = ~controller_data_in_B[c];
      end
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      idx              <= '0;
      shreg            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      controller_latch <= 1'b0;
      controller_clk   <= 1'b0;
      buttons_out      <= '0;
`ifdef CONTROLLER_PRESSED_EDGE_EN
      pressed_out      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_LATCH;
            cnt              <= '0;
            busy             <= 1'b1;
            controller_latch <= 1'b1;
          end
        end
        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            state            <= S_READ;
            controller_latch <= 1'b0;
            idx              <= '0;
            cnt              <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READ: begin
          shreg <= sampled;
          if (idx == IDX_LAST) begin
            state       <= S_DONE;
            done        <= 1'b1;
            buttons_out <= sampled;
`ifdef CONTROLLER_PRESSED_EDGE_EN
            pressed_out <= sampled & ~buttons_out;
`endif
          end else begin
            state          <= S_CLK_HIGH;
            controller_clk <= 1'b1;
            cnt            <= '0;
          end
        end
        S_CLK_HIGH: begin
          if (cnt == HALF_LAST) begin
            state          <= S_CLK_LOW;
            controller_clk <= 1'b0;
            cnt            <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CLK_LOW: begin
          if (cnt == HALF_LAST) begin
            state <= S_READ;
            idx   <= idx + 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_controller_poll.sv
// tb/tb_multi_controller_poll.sv - directed-vector bench for multi_controller_poll
// Default instance (2 pads x 8) plus a 4 pad x 12 button, CLK_DIV=1 instance.
module tb_multi_controller_poll;

  logic        clk_1 = 1'b0;
  logic        rst, start, busy, done, lat, ck;
  logic [1:0]  data_b;
  logic [15:0] buttons;
  logic        rst_w, start_w, busy_w, done_w, lat_w, ck_w;
  logic [3:0]  data_bw;
  logic [47:0] buttons_w;
`ifdef CONTROLLER_PRESSED_EDGE_EN
  logic [15:0] pressed;
  logic [47:0] pressed_w;
`endif

  always #5 clk_1 = ~clk_1;

  multi_controller_poll u_dut (
    .clk_1(clk_1), .rst(rst), .start(start), .busy(busy), .done(done),
    .controller_latch(lat), .controller_clk(ck),
    .controller_data_in_B(data_b), .buttons_out(buttons)
`ifdef CONTROLLER_PRESSED_EDGE_EN
    , .pressed_out(pressed)
`endif
  );

  multi_controller_poll #(.NUM_CONTROLLERS(4), .BUTTONS(12), .CLK_DIV(1)) u_wide (
    .clk_1(clk_1), .rst(rst_w), .start(start_w), .busy(busy_w), .done(done_w),
    .controller_latch(lat_w), .controller_clk(ck_w),
    .controller_data_in_B(data_bw), .buttons_out(buttons_w)
`ifdef CONTROLLER_PRESSED_EDGE_EN
    , .pressed_out(pressed_w)
`endif
  );

  // Behavioural pads: latch reloads bit 0, each clock rising edge advances.
  logic [7:0]  pad_a [2];
  logic [11:0] pad_w [4];
  int pidx_a = 0;
  int pidx_w = 0;
  always @(posedge lat)  pidx_a = 0;
  always @(posedge ck)   pidx_a = pidx_a + 1;
  always @(posedge lat_w) pidx_w = 0;
  always @(posedge ck_w)  pidx_w = pidx_w + 1;

  always_comb begin
    for (int c = 0; c < 2; c++) data_b[c] = (pidx_a < 8) ? ~pad_a[c][pidx_a] : 1'b1;
    for (int c = 0; c < 4; c++) data_bw[c] = (pidx_w < 12) ? ~pad_w[c][pidx_w] : 1'b1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_1);
    #1;
  endtask

  int lat_cnt, lat_first, clk_hi, clk_rise, run_bad, run_len, done_cnt, done_cyc, overlap;
  logic busy73, busy74, prev_ck;
  logic [15:0] btn_done;

  // Observe cycles 1..n of a poll kicked in cycle 0; start pulses at cycles sa/sb.
  task automatic observe(input int n, input int sa, input int sb);
    lat_cnt = 0; lat_first = -1; clk_hi = 0; clk_rise = 0; run_bad = 0; run_len = 0;
    done_cnt = 0; done_cyc = -1; overlap = 0; prev_ck = 1'b0; busy73 = 1'b0; busy74 = 1'b1;
    btn_done = '0;
    for (int i = 1; i <= n; i++) begin
      if (lat) begin
        lat_cnt++;
        if (lat_first < 0) lat_first = i;
      end
      if (ck) begin
        clk_hi++;
        run_len++;
        if (!prev_ck) clk_rise++;
      end else begin
        if (prev_ck && run_len != 4) run_bad++;
        run_len = 0;
      end
      prev_ck = ck;
      if (lat && ck) overlap++;
      if (done) begin
        done_cnt++;
        done_cyc = i;
        btn_done = buttons;
      end
      if (i == 73) busy73 = busy;
      if (i == 74) busy74 = busy;
      start = (i == sa) || (i == sb);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic kick;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [15:0] held_btn [2];
  int held_cyc [2];
  int nheld;

  initial begin
    rst = 1'b1; start = 1'b0; rst_w = 1'b1; start_w = 1'b0;
    pad_a[0] = 8'hA5; pad_a[1] = 8'h3C;
    pad_w[0] = 12'hFFF; pad_w[1] = 12'h000; pad_w[2] = 12'h801; pad_w[3] = 12'h000;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_latch", lat, 1'b0);
    check("rst_clk", ck, 1'b0);
    check("rst_buttons", buttons, 16'h0);
    rst = 1'b0; rst_w = 1'b0;
    tick();

    // Basic poll with default parameters
    kick();
    observe(80, -1, -1);
    check("basic_latch_cycles", lat_cnt, 8);
    check("basic_latch_first", lat_first, 1);
    check("basic_clk_pulses", clk_rise, 7);
    check("basic_clk_high_total", clk_hi, 28);
    check("basic_clk_run_len", run_bad, 0);
    check("basic_overlap", overlap, 0);
    check("basic_done_cycle", done_cyc, 73);
    check("basic_done_count", done_cnt, 1);
    check("basic_buttons_at_done", btn_done, 16'h3CA5);
    check("basic_busy_73", busy73, 1'b1);
    check("basic_busy_74", busy74, 1'b0);
    check("basic_buttons_hold", buttons, 16'h3CA5);

    // Reset in cycle 40 of a poll aborts it
    pad_a[0] = 8'h5A; pad_a[1] = 8'hC3;
    kick();
    for (int i = 1; i < 40; i++) tick();
    rst = 1'b1;
    tick();
    check("abort_latch", lat, 1'b0);
    check("abort_clk", ck, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_buttons", buttons, 16'h0);
    rst = 1'b0;
    tick();
    kick();
    observe(80, -1, -1);
    check("after_abort_done_cycle", done_cyc, 73);
    check("after_abort_buttons", btn_done, 16'hC35A);

    // start while busy / in DONE is ignored
    pad_a[0] = 8'h81; pad_a[1] = 8'h7E;
    kick();
    observe(95, 20, 73);
    check("ignore_done_count", done_cnt, 1);
    check("ignore_latch_cycles", lat_cnt, 8);
    check("ignore_buttons", btn_done, 16'h7E81);
    check("ignore_busy_74", busy74, 1'b0);

    // start held high: back-to-back polls
    pad_a[0] = 8'h01; pad_a[1] = 8'h00;
    nheld = 0;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 160; i++) begin
      if (done && nheld < 2) begin
        held_btn[nheld] = buttons;
        held_cyc[nheld] = i;
        nheld++;
      end
      if (i == 74) pad_a[0] = 8'h80;
      if (i == 147) start = 1'b0;
      tick();
    end
    check("held_done_count", nheld, 2);
    check("held_first_cycle", held_cyc[0], 73);
    check("held_first_value", held_btn[0], 16'h0001);
    check("held_second_cycle", held_cyc[1], 147);
    check("held_second_value", held_btn[1], 16'h0080);
    for (int i = 0; i < 80 && busy; i++) tick();
    check("held_idle_after", busy, 1'b0);

    // Wide instance: 4 pads x 12 buttons, CLK_DIV=1, pad 3 unplugged
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    done_cnt = 0; done_cyc = -1;
    for (int i = 1; i <= 45; i++) begin
      if (done_w) begin
        done_cnt++;
        done_cyc = i;
      end
      tick();
    end
    check("wide_done_cycle", done_cyc, 37);
    check("wide_done_count", done_cnt, 1);
    check("wide_buttons", buttons_w, 48'h000_801_000_FFF);
    check("wide_busy_after", busy_w, 1'b0);

`ifdef CONTROLLER_PRESSED_EDGE_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pad_a[0] = 8'h03; pad_a[1] = 8'h00;
    kick();
    observe(80, -1, -1);
    check("pressed_first", pressed[7:0], 8'h03);
    pad_a[0] = 8'h06;
    kick();
    observe(80, -1, -1);
    check("pressed_second", pressed[7:0], 8'h04);
    check("pressed_buttons", buttons, 16'h0006);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
